// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with pointer-difference occupancy, registered over/underflow pulses and a
// choice of registered-read or first-word-fall-through output.
module param_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADD_WIDTH  = 4,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned AF_LEVEL   = 12,
  parameter int unsigned AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADD_WIDTH:0]    fifo_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned Depth = 1 << ADD_WIDTH;
  localparam int unsigned PtrW  = ADD_WIDTH + 1;

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [ADD_WIDTH-1:0]  wr_addr, rd_addr;
  logic                  rd_accept, wr_accept;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] mem_q [Depth];

  assign wr_addr = wr_ptr_q[ADD_WIDTH-1:0];
  assign rd_addr = rd_ptr_q[ADD_WIDTH-1:0];

  // Status decode, purely from the pointer registers.
  assign fifo_count   = wr_ptr_q - rd_ptr_q;
  assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
  assign fifo_full    = (wr_ptr_q[ADD_WIDTH] != rd_ptr_q[ADD_WIDTH]) && (wr_addr == rd_addr);
  assign almost_full  = (fifo_count >= PtrW'(AF_LEVEL));
  assign almost_empty = (fifo_count <= PtrW'(AE_LEVEL));
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Accept logic and next pointers; a full FIFO still takes a write if a pop frees a slot.
  always_comb begin
    rd_accept   = rd_en && !fifo_empty;
    wr_accept   = wr_en && (!fifo_full || rd_accept);
    wr_ptr_d    = wr_accept ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d    = rd_accept ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    overflow_d  = wr_en && !wr_accept;
    underflow_d = rd_en && !rd_accept;
  end

  // Pointer and error-pulse state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_addr] <= data_in;
    end
  end

  if (FWFT == 0) begin : g_std_read
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dvalid_q, dvalid_d;

    // Registered read: capture head on pop, hold otherwise.
    always_comb begin
      dout_d   = rd_accept ? mem_q[rd_addr] : dout_q;
      dvalid_d = rd_accept;
    end

    // Output register.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dout_q   <= '0;
        dvalid_q <= 1'b0;
      end else begin
        dout_q   <= dout_d;
        dvalid_q <= dvalid_d;
      end
    end

    assign data_out   = dout_q;
    assign data_valid = dvalid_q;
  end else begin : g_fwft_read
    // Head word presented directly; forced to zero when empty so reset shows data_out = 0.
    assign data_out   = fifo_empty ? '0 : mem_q[rd_addr];
    assign data_valid = !fifo_empty;
  end

endmodule
